// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART definitions: default bit period and receiver state encoding.
// Also imported by the transmitter so both ends agree on the 9600-baud constant.
package uart_rx_8n1_pkg;

    localparam int CLKS_PER_BIT_9600 = 1250;
    localparam int SYNC_DEPTH        = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Consumer-side bus of the 8N1 receiver: one-entry byte holding register with level valid and ack.
// master = receiver, slave = consumer.
interface uart_rx_8n1_if;

    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       rxack;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rxbyte, rxvalid, framing_err, overrun, busy,
        input  rxack
    );

    modport slave (
        input  rxbyte, rxvalid, framing_err, overrun, busy,
        output rxack
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX line; latency DEPTH clocks.
// No backpressure; resets to RESET_VAL so an idle-high line shows no edge.
module uart_rx_sync #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {DEPTH{RESET_VAL}};
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 receiver with one-entry holding register; rxvalid rises ~9.5 bit periods after the start edge.
// RX cannot be stalled: a byte completing while rxvalid=1 and rxack=0 is dropped and sets overrun.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RX,
    uart_rx_8n1_if.master bus
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic                  rx_s;
    logic                  rx_d;
    logic [SYNC_DEPTH-1:0] warm;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  tick;
    logic                  fall;
    logic                  cnt_run;
    logic                  shift_en;
    logic                  accept;
    logic                  ferr;
    logic [7:0]            rxbyte_q;
    logic                  rxvalid_q;
    logic                  ferr_q;
    logic                  overrun_q;
    logic                  busy_q;

    uart_rx_sync #(
        .DEPTH     (SYNC_DEPTH),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (RX),
        .dout (rx_s)
    );

    // rx_d stays low until the synchronizer has flushed its reset value, so a line
    // that is already low when reset releases never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm <= '0;
            rx_d <= 1'b0;
        end else begin
            warm <= {warm[SYNC_DEPTH-2:0], 1'b1};
            rx_d <= warm[SYNC_DEPTH-1] & rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;
    assign tick = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (fall) state_nxt = ST_START;
            ST_START:     if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (tick && (bit_cnt == 3'd7)) state_nxt = ST_STOP;
            ST_STOP:      if (tick) state_nxt = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_run  = 1'b0;
        shift_en = 1'b0;
        accept   = 1'b0;
        ferr     = 1'b0;
        case (state)
            ST_START: cnt_run = 1'b1;
            ST_DATA: begin
                cnt_run  = 1'b1;
                shift_en = tick;
            end
            ST_STOP: begin
                cnt_run = 1'b1;
                accept  = tick & rx_s;
                ferr    = tick & ~rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (!cnt_run || tick) cnt <= '0;
            else                  cnt <= cnt + 1'b1;
            if (state == ST_IDLE) bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // An ack in the accept cycle frees the slot, so the new byte loads without overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxbyte_q  <= 8'h00;
            rxvalid_q <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ferr_q <= ferr;
            busy_q <= (state_nxt != ST_IDLE);
            if (accept && (!rxvalid_q || bus.rxack)) begin
                rxbyte_q  <= shreg;
                rxvalid_q <= 1'b1;
            end else if (rxvalid_q && bus.rxack) begin
                rxvalid_q <= 1'b0;
            end
            if (accept && rxvalid_q && !bus.rxack) overrun_q <= 1'b1;
            else if (rxvalid_q && bus.rxack)       overrun_q <= 1'b0;
        end
    end

    assign bus.rxbyte      = rxbyte_q;
    assign bus.rxvalid     = rxvalid_q;
    assign bus.framing_err = ferr_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = busy_q;

endmodule
